// File: rtl/fp_wb_pkg.sv
// rtl/fp_wb_pkg.sv - shared widths and queue entry type for the FP writeback queue
package fp_wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } fp_wb_entry_t;

endpackage

// File: rtl/fp_writeback_queue_if.sv
// rtl/fp_writeback_queue_if.sv - producer, load and register-file write port bundle
interface fp_writeback_queue_if #(
    parameter int DATA_W = fp_wb_pkg::DATA_W,
    parameter int ADDR_W = fp_wb_pkg::ADDR_W
);
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_rd;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_rd;
    logic [DATA_W-1:0] b_data;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_rd;
    logic [DATA_W-1:0] ld_data;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_reg;
    logic [DATA_W-1:0] wb_data;

    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data, ld_valid, ld_rd, ld_data,
        output a_ready, b_ready, wb_en, wb_reg, wb_data
    );

    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data, ld_valid, ld_rd, ld_data,
        input  a_ready, b_ready, wb_en, wb_reg, wb_data
    );
endinterface

// File: rtl/fp_wb_fifo.sv
// rtl/fp_wb_fifo.sv - entry storage with wrapping pointers, occupancy and per-slot valid flags
module fp_wb_fifo import fp_wb_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fp_wb_entry_t             push_entry,
    input  logic                     pop,
    output fp_wb_entry_t             head,
    output logic [ADDR_W-1:0]        rds [DEPTH],
    output logic [DEPTH-1:0]         valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fp_wb_entry_t       mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   offset;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is deliberately left unreset; valid flags gate every use of it.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        valid  = '0;
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rds[i]   = mem[i].rd;
            offset   = PTR_W'(i) - rd_ptr;
            valid[i] = (CNT_W'(offset) < count);
        end
    end
endmodule

// File: rtl/fp_writeback_queue.sv
// rtl/fp_writeback_queue.sv - arbitrates FP ALU/divider results into a FIFO draining to the FP register file
module fp_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = fp_wb_pkg::DATA_W,
    parameter int ADDR_W = fp_wb_pkg::ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fp_writeback_queue_if.slave    bus,
    input  logic [ADDR_W-1:0]      chk_rs1,
    input  logic [ADDR_W-1:0]      chk_rs2,
    output logic                   chk_rs1_busy,
    output logic                   chk_rs2_busy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    import fp_wb_pkg::*;

    fp_wb_entry_t       push_entry;
    fp_wb_entry_t       head;
    logic [ADDR_W-1:0]  rds [DEPTH];
    logic [DEPTH-1:0]   valid;
    logic               a_acc;
    logic               b_acc;
    logic               push;
    logic               pop;

    assign bus.a_ready = !full;
    assign bus.b_ready = !full && !bus.a_valid;
    assign a_acc       = bus.a_valid && bus.a_ready;
    assign b_acc       = bus.b_valid && bus.b_ready;

    // f0 is hardwired zero, so a result aimed at it is accepted and dropped.
    always_comb begin
        push_entry.rd   = a_acc ? bus.a_rd   : bus.b_rd;
        push_entry.data = a_acc ? bus.a_data : bus.b_data;
        push            = (a_acc || b_acc) && (push_entry.rd != '0);
    end

    fp_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .rds        (rds),
        .valid      (valid),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    // Loads own the port outright; the queue only drains on load-free cycles.
    always_comb begin
        bus.wb_en   = 1'b0;
        bus.wb_reg  = '0;
        bus.wb_data = '0;
        pop         = 1'b0;
        if (!rst_n) begin
            pop = 1'b0;
        end else if (bus.ld_valid) begin
            bus.wb_en   = 1'b1;
            bus.wb_reg  = bus.ld_rd;
            bus.wb_data = bus.ld_data;
        end else if (!empty) begin
            bus.wb_en   = 1'b1;
            bus.wb_reg  = head.rd;
            bus.wb_data = head.data;
            pop         = 1'b1;
        end
    end

    always_comb begin
        chk_rs1_busy = 1'b0;
        chk_rs2_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && rds[i] == chk_rs1) chk_rs1_busy = 1'b1;
            if (valid[i] && rds[i] == chk_rs2) chk_rs2_busy = 1'b1;
        end
        if (chk_rs1 == '0) chk_rs1_busy = 1'b0;
        if (chk_rs2 == '0) chk_rs2_busy = 1'b0;
    end
endmodule

// File: tb/tb_fp_writeback_queue.sv
// tb/tb_fp_writeback_queue.sv - directed table-driven bench for fp_writeback_queue
module tb_fp_writeback_queue;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] chk_rs1 = '0;
    logic [4:0] chk_rs2 = '0;
    logic       chk_rs1_busy;
    logic       chk_rs2_busy;
    logic [2:0] count;
    logic       full;
    logic       empty;
    int         passed = 0;
    int         total  = 0;

    fp_writeback_queue_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    fp_writeback_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .chk_rs1      (chk_rs1),
        .chk_rs2      (chk_rs2),
        .chk_rs1_busy (chk_rs1_busy),
        .chk_rs2_busy (chk_rs2_busy),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        a_v;  logic [4:0] a_rd;  logic [31:0] a_d;
        logic        b_v;  logic [4:0] b_rd;  logic [31:0] b_d;
        logic        l_v;  logic [4:0] l_rd;  logic [31:0] l_d;
        logic [4:0]  c1;   logic [4:0] c2;
        logic        e_ar; logic e_br; logic e_wen;
        logic [4:0]  e_reg; logic [31:0] e_data; logic [2:0] e_cnt;
        logic        e_b1; logic e_b2;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(
        input logic a_v, input logic [4:0] a_rd, input logic [31:0] a_d,
        input logic b_v, input logic [4:0] b_rd, input logic [31:0] b_d,
        input logic l_v, input logic [4:0] l_rd, input logic [31:0] l_d,
        input logic [4:0] c1, input logic [4:0] c2,
        input logic e_ar, input logic e_br, input logic e_wen,
        input logic [4:0] e_reg, input logic [31:0] e_data, input logic [2:0] e_cnt,
        input logic e_b1, input logic e_b2);
        vec_t v;
        v.a_v = a_v; v.a_rd = a_rd; v.a_d = a_d;
        v.b_v = b_v; v.b_rd = b_rd; v.b_d = b_d;
        v.l_v = l_v; v.l_rd = l_rd; v.l_d = l_d;
        v.c1 = c1; v.c2 = c2;
        v.e_ar = e_ar; v.e_br = e_br; v.e_wen = e_wen;
        v.e_reg = e_reg; v.e_data = e_data; v.e_cnt = e_cnt;
        v.e_b1 = e_b1; v.e_b2 = e_b2;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else passed++;
    endtask

    task automatic drive(input logic a_v, input logic [4:0] a_rd, input logic [31:0] a_d,
                         input logic b_v, input logic [4:0] b_rd, input logic [31:0] b_d,
                         input logic l_v, input logic [4:0] l_rd, input logic [31:0] l_d);
        bus.a_valid = a_v;  bus.a_rd = a_rd;  bus.a_data = a_d;
        bus.b_valid = b_v;  bus.b_rd = b_rd;  bus.b_data = b_d;
        bus.ld_valid = l_v; bus.ld_rd = l_rd; bus.ld_data = l_d;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        check("rst count", 32'(count), 0);
        check("rst empty", 32'(empty), 1);
        check("rst full", 32'(full), 0);
        check("rst wb_en", 32'(bus.wb_en), 0);
        check("rst a_ready", 32'(bus.a_ready), 1);
        check("rst b_ready", 32'(bus.b_ready), 1);
        #1 rst_n = 1'b1;

        //         a_v rd  data          b_v rd data          l_v rd data          c1 c2  ar br wen reg data          cnt b1 b2
        vecs.push_back(mk(1, 3, 32'h3F800000, 0, 0, 0,            0, 0, 0,            0, 0,  1, 0, 0, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0,            3, 0,  1, 1, 1, 3, 32'h3F800000, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0,            3, 0,  1, 1, 0, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk(1, 4, 32'h40800000, 1, 5, 32'h40A00000, 0, 0, 0,            0, 0,  1, 0, 0, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            1, 5, 32'h40A00000, 0, 0, 0,            4, 5,  1, 1, 1, 4, 32'h40800000, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0,            4, 5,  1, 1, 1, 5, 32'h40A00000, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0,            0, 0,  1, 1, 0, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk(1, 1, 32'h11,       0, 0, 0,            1, 9, 32'hC0FFEE09, 0, 0,  1, 0, 1, 9, 32'hC0FFEE09, 0, 0, 0));
        vecs.push_back(mk(1, 2, 32'h12,       0, 0, 0,            1, 9, 32'hC0FFEE09, 0, 0,  1, 0, 1, 9, 32'hC0FFEE09, 1, 0, 0));
        vecs.push_back(mk(1, 3, 32'h13,       0, 0, 0,            1, 9, 32'hC0FFEE09, 0, 0,  1, 0, 1, 9, 32'hC0FFEE09, 2, 0, 0));
        vecs.push_back(mk(1, 4, 32'h14,       0, 0, 0,            1, 9, 32'hC0FFEE09, 0, 0,  1, 0, 1, 9, 32'hC0FFEE09, 3, 0, 0));
        vecs.push_back(mk(1, 5, 32'h15,       0, 0, 0,            1, 9, 32'hC0FFEE09, 0, 0,  0, 0, 1, 9, 32'hC0FFEE09, 4, 0, 0));
        vecs.push_back(mk(1, 5, 32'h15,       0, 0, 0,            1, 0, 32'hAAAA0000, 3, 5,  0, 0, 1, 0, 32'hAAAA0000, 4, 1, 0));
        vecs.push_back(mk(1, 5, 32'h15,       0, 0, 0,            0, 0, 0,            1, 0,  0, 0, 1, 1, 32'h11,       4, 1, 0));
        vecs.push_back(mk(1, 5, 32'h15,       0, 0, 0,            0, 0, 0,            0, 0,  1, 0, 1, 2, 32'h12,       3, 0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0,            0, 0,  1, 1, 1, 3, 32'h13,       3, 0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0,            0, 0,  1, 1, 1, 4, 32'h14,       2, 0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0,            5, 0,  1, 1, 1, 5, 32'h15,       1, 1, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0,            5, 0,  1, 1, 0, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk(1, 0, 32'hDEAD,     0, 0, 0,            0, 0, 0,            0, 0,  1, 0, 0, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0,            0, 0,  1, 1, 0, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            1, 0, 32'hBEEF,     0, 0, 0,            0, 0,  1, 1, 0, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0,            0, 0,  1, 1, 0, 0, 32'h0,        0, 0, 0));

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i].a_v, vecs[i].a_rd, vecs[i].a_d, vecs[i].b_v, vecs[i].b_rd, vecs[i].b_d,
                  vecs[i].l_v, vecs[i].l_rd, vecs[i].l_d);
            chk_rs1 = vecs[i].c1;
            chk_rs2 = vecs[i].c2;
            @(negedge clk);
            check($sformatf("v%0d a_ready", i), 32'(bus.a_ready), 32'(vecs[i].e_ar));
            check($sformatf("v%0d b_ready", i), 32'(bus.b_ready), 32'(vecs[i].e_br));
            check($sformatf("v%0d wb_en", i), 32'(bus.wb_en), 32'(vecs[i].e_wen));
            check($sformatf("v%0d wb_reg", i), 32'(bus.wb_reg), 32'(vecs[i].e_reg));
            check($sformatf("v%0d wb_data", i), bus.wb_data, vecs[i].e_data);
            check($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].e_cnt));
            check($sformatf("v%0d full", i), 32'(full), 32'(vecs[i].e_cnt == 3'd4));
            check($sformatf("v%0d empty", i), 32'(empty), 32'(vecs[i].e_cnt == 3'd0));
            check($sformatf("v%0d busy1", i), 32'(chk_rs1_busy), 32'(vecs[i].e_b1));
            check($sformatf("v%0d busy2", i), 32'(chk_rs2_busy), 32'(vecs[i].e_b2));
        end

        // rd 7 held in the queue behind a load, then drained
        @(posedge clk); #1;
        drive(1, 7, 32'h77, 0, 0, 0, 1, 8, 32'h88);
        chk_rs1 = 5'd7;
        chk_rs2 = 5'd0;
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 1, 8, 32'h88);
        @(negedge clk);
        check("rd7 busy1 queued", 32'(chk_rs1_busy), 1);
        check("rd7 busy2 f0", 32'(chk_rs2_busy), 0);
        check("rd7 count", 32'(count), 1);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rd7 wb_reg", 32'(bus.wb_reg), 7);
        check("rd7 busy while popping", 32'(chk_rs1_busy), 1);
        @(negedge clk);
        check("rd7 busy cleared", 32'(chk_rs1_busy), 0);
        check("rd7 wb_en idle", 32'(bus.wb_en), 0);

        // mid-operation reset with three entries queued
        chk_rs1 = 5'd11;
        @(posedge clk); #1;
        drive(1, 10, 32'hA, 0, 0, 0, 1, 9, 32'h9);
        @(posedge clk); #1;
        drive(1, 11, 32'hB, 0, 0, 0, 1, 9, 32'h9);
        @(posedge clk); #1;
        drive(1, 12, 32'hC, 0, 0, 0, 1, 9, 32'h9);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("prerst count", 32'(count), 3);
        check("prerst wb_reg", 32'(bus.wb_reg), 10);
        check("prerst busy1", 32'(chk_rs1_busy), 1);
        rst_n = 1'b0;
        #1;
        check("rst mid count", 32'(count), 0);
        check("rst mid wb_en", 32'(bus.wb_en), 0);
        check("rst mid empty", 32'(empty), 1);
        check("rst mid busy1", 32'(chk_rs1_busy), 0);
        check("rst mid a_ready", 32'(bus.a_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("post rst wb_en c%0d", k), 32'(bus.wb_en), 0);
            check($sformatf("post rst count c%0d", k), 32'(count), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fp_writeback_queue.md
# fp_writeback_queue

Write-side master for the 32×32 FP register file: collects results from the FP ALU (source A) and the FP divide/sqrt unit (source B), buffers them in a small FIFO, and drives the register file write port (writeRegister/writeData/regWrite). FP loads from the LSU own the write port with absolute priority, so the queue drains only on cycles without a load write. It also reports pending writes per source register so decode can stall on RAW hazards.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- DATA_W, 32, result width
- ADDR_W, 5, register index width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- a_valid  in  1  FP ALU result valid
- a_ready  out  1  FP ALU result accepted
- a_rd  in  ADDR_W  destination register, source A
- a_data  in  DATA_W  result, source A
- b_valid  in  1  div/sqrt result valid
- b_ready  out  1  div/sqrt result accepted
- b_rd  in  ADDR_W  destination register, source B
- b_data  in  DATA_W  result, source B
- ld_valid  in  1  LSU FP load writing this cycle (no backpressure)
- ld_rd  in  ADDR_W  load destination
- ld_data  in  DATA_W  load data
- wb_en  out  1  to regWrite
- wb_reg  out  ADDR_W  to writeRegister
- wb_data  out  DATA_W  to writeData
- chk_rs1, chk_rs2  in  ADDR_W  registers to check for pending writes
- chk_rs1_busy, chk_rs2_busy  out  1  queued write pending to chk_rsN
- count  out  $clog2(DEPTH)+1  occupancy
- full, empty  out  1  count==DEPTH / count==0

## Operation
- Arbitration, fixed priority A over B: a_ready = !full; b_ready = !full && !a_valid. At most one accept per cycle.
- Accept = valid && ready at a rising edge. Producers hold valid/rd/data until accepted.
- Accepted result with rd==0 is consumed and discarded (f0 is hardwired zero); not enqueued, count unchanged.
- Write port mux: ld_valid → wb_en=1, wb_reg=ld_rd, wb_data=ld_data, no dequeue. Else !empty → wb_en=1, head entry driven, head popped at the edge. Else wb_en=0, wb_reg=0, wb_data=0.
- ld_valid with ld_rd==0 still owns the port (register file ignores f0).
- Strict FIFO order; no reordering or merging of same-rd entries. Load-vs-queued ordering on the same rd is decode's job via busy.
- chk_rsN_busy = OR over valid entries of (entry.rd == chk_rsN); forced 0 when chk_rsN==0. The entry being popped this cycle still counts as busy.
- Simultaneous push and pop: count unchanged; legal even when full (a_ready is still 0 when full, so push-at-full cannot happen).

## Timing
- Reset (async assert, sync-timed deassert): pointers 0, count 0, empty=1, full=0, wb_en=0, wb_reg=0, wb_data=0, busy=0, a_ready=1, b_ready=!a_valid. Entry storage not reset.
- Latency: accept at edge N → earliest wb_en for it in cycle N+1 (register file writes at edge N+1). No combinational path from a_*/b_* to wb_*.
- ld_* → wb_* combinational, same cycle.
- busy reflects state after edge; purely combinational from chk_rs and queue contents.
- Pointers wrap modulo DEPTH; count distinguishes full from empty.
- rst_n asserted mid-operation: all queued writes dropped, wb_en=0 immediately.

## Structure
- Package fp_wb_pkg: DATA_W, ADDR_W constants; fp_wb_entry_t {rd, data}.
- Sub-module fp_wb_fifo: storage, wrapping pointers, count/full/empty, per-entry valid vector for busy compare. Top holds arbitration, f0 drop, write-port mux, busy logic.

## Test plan
- Reset, then a_valid=1, a_rd=3, a_data=32'h3F800000 → a_ready=1; next cycle wb_en=1, wb_reg=3, wb_data=32'h3F800000; then empty=1.
- a_valid and b_valid same cycle (rd 4, rd 5) → b_ready=0, A written first, B accepted next cycle, written one cycle later.
- ld_valid held 6 cycles while A pushes rd 1..5 → count reaches 4, full=1, a_ready=0; after ld_valid drops, writes appear in order rd 1..4, then 5.
- a_rd=0 accepted → no enqueue, count stays 0, wb_en stays 0.
- Queue holding rd 7 and chk_rs1=7, chk_rs2=0 → chk_rs1_busy=1, chk_rs2_busy=0; busy clears the cycle after rd 7 is popped.
- rst_n low for one cycle with 3 entries queued → count=0, wb_en=0 immediately; no stale writes after release.
